// File: rtl/uart_tx_sequencer_pkg.sv
// Shared definitions for the UART transmit sequencer: FSM state encoding,
// common baud divisors for a 100 MHz fabric clock, and the divisor floor.
package uart_tx_sequencer_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StData   = 3'd2,
        StParity = 3'd3,
        StStop   = 3'd4
    } tx_state_e;

    // Cycles per bit at 100 MHz.
    localparam int unsigned DIV_9600  = 10417;
    localparam int unsigned DIV_19200 = 5208;

    // Smallest usable divisor; anything lower is clamped up to this.
    localparam int unsigned MIN_DIV = 2;

endpackage

// File: rtl/uart_tx_sequencer_baud_tick_gen.sv
// Baud tick generator: holds the runtime divisor and produces a one-cycle
// enable at the end of every bit period. No divided clock is produced.
// Ports:
//   i_clk_in   clock, all logic on posedge
//   i_tx_rst   synchronous active-high reset
//   i_clr      clear the bit counter (frame start)
//   i_en       counter runs while high (sequencer not idle)
//   i_div_val  new cycles-per-bit value
//   i_div_ld   load strobe, honoured only while i_en is low
//   o_tick     one-cycle pulse when the counter reaches div-1
module uart_tx_sequencer_baud_tick_gen
    import uart_tx_sequencer_pkg::*;
#(
    parameter int unsigned DIV_W       = 16,
    parameter int unsigned DEFAULT_DIV = DIV_9600
) (
    input  logic             i_clk_in,
    input  logic             i_tx_rst,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [DIV_W-1:0] i_div_val,
    input  logic             i_div_ld,
    output logic             o_tick
);

    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] r_count;
    logic             w_wrap;

    assign w_wrap = (r_count == r_div - DIV_W'(1));
    assign o_tick = i_en & w_wrap;

    always_ff @(posedge i_clk_in) begin
        if (i_tx_rst) begin
            r_div   <= DIV_W'(DEFAULT_DIV);
            r_count <= '0;
        end else begin
            // Divisor may only change between frames so a bit is never cut short.
            if (i_div_ld && !i_en) begin
                r_div <= (i_div_val < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : i_div_val;
            end
            if (i_clr) begin
                r_count <= '0;
            end else if (i_en) begin
                r_count <= w_wrap ? '0 : r_count + DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/uart_tx_sequencer.sv
// UART transmit sequencer: accepts a byte per valid/ready handshake and
// serialises it as start, LSB-first data, optional even parity, stop bit(s).
// Ports:
//   i_clk_in    100 MHz clock
//   i_tx_rst    synchronous active-high reset
//   i_div_val   new cycles-per-bit value
//   i_div_ld    divisor load strobe (accepted only when idle)
//   o_div_err   one-cycle pulse when a load was rejected
//   i_par_en    insert even parity bit, sampled at handshake
//   i_tx_data   byte to send
//   i_tx_valid  source has a byte
//   o_tx_ready  sequencer can accept a byte this cycle
//   o_tx_out    serial line, idle high
//   o_tx_busy   frame in progress
//   o_tx_done   one-cycle pulse after the last stop bit
module uart_tx_sequencer
    import uart_tx_sequencer_pkg::*;
#(
    parameter int unsigned DIV_W       = 16,
    parameter int unsigned DEFAULT_DIV = DIV_9600,
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned STOP_BITS   = 1
) (
    input  logic                 i_clk_in,
    input  logic                 i_tx_rst,
    input  logic [DIV_W-1:0]     i_div_val,
    input  logic                 i_div_ld,
    output logic                 o_div_err,
    input  logic                 i_par_en,
    input  logic [DATA_BITS-1:0] i_tx_data,
    input  logic                 i_tx_valid,
    output logic                 o_tx_ready,
    output logic                 o_tx_out,
    output logic                 o_tx_busy,
    output logic                 o_tx_done
);

    localparam int unsigned IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
    localparam logic [1:0]       STOP_LAST = 2'(STOP_BITS - 1);

    tx_state_e            r_state, w_state_d;
    logic [IDX_W-1:0]     r_bit_idx, w_bit_idx_d;
    logic [1:0]           r_stop_idx, w_stop_idx_d;
    logic [DATA_BITS-1:0] r_shift, w_shift_d;
    logic                 r_par_en, w_par_en_d;
    logic                 r_par_bit, w_par_bit_d;
    logic                 r_tx_out, w_tx_out_d;
    logic                 r_busy, w_busy_d;
    logic                 r_done, w_done_d;
    logic                 r_ready, w_ready_d;
    logic                 r_div_err, w_div_err_d;
    logic                 w_hs;
    logic                 w_tick;

    assign w_hs = i_tx_valid & r_ready;

    uart_tx_sequencer_baud_tick_gen #(
        .DIV_W       (DIV_W),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) u_baud_tick_gen (
        .i_clk_in  (i_clk_in),
        .i_tx_rst  (i_tx_rst),
        .i_clr     (w_hs),
        .i_en      (r_state != StIdle),
        .i_div_val (i_div_val),
        .i_div_ld  (i_div_ld),
        .o_tick    (w_tick)
    );

    // State register; outputs are registered so they are glitch-free at the pin.
    always_ff @(posedge i_clk_in) begin
        if (i_tx_rst) begin
            r_state    <= StIdle;
            r_bit_idx  <= '0;
            r_stop_idx <= '0;
            r_shift    <= '0;
            r_par_en   <= 1'b0;
            r_par_bit  <= 1'b0;
            r_tx_out   <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_ready    <= 1'b1;
            r_div_err  <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_bit_idx  <= w_bit_idx_d;
            r_stop_idx <= w_stop_idx_d;
            r_shift    <= w_shift_d;
            r_par_en   <= w_par_en_d;
            r_par_bit  <= w_par_bit_d;
            r_tx_out   <= w_tx_out_d;
            r_busy     <= w_busy_d;
            r_done     <= w_done_d;
            r_ready    <= w_ready_d;
            r_div_err  <= w_div_err_d;
        end
    end

    // Next-state and datapath.
    always_comb begin
        w_state_d    = r_state;
        w_bit_idx_d  = r_bit_idx;
        w_stop_idx_d = r_stop_idx;
        w_shift_d    = r_shift;
        w_par_en_d   = r_par_en;
        w_par_bit_d  = r_par_bit;
        case (r_state)
            StIdle: begin
                if (w_hs) begin
                    w_state_d   = StStart;
                    w_shift_d   = i_tx_data;
                    w_par_en_d  = i_par_en;
                    w_par_bit_d = ^i_tx_data;
                end
            end
            StStart: begin
                if (w_tick) begin
                    w_state_d   = StData;
                    w_bit_idx_d = '0;
                end
            end
            StData: begin
                if (w_tick) begin
                    if (r_bit_idx == IDX_LAST) begin
                        w_state_d    = r_par_en ? StParity : StStop;
                        w_stop_idx_d = '0;
                    end else begin
                        w_bit_idx_d = r_bit_idx + IDX_W'(1);
                        w_shift_d   = r_shift >> 1;
                    end
                end
            end
            StParity: begin
                if (w_tick) begin
                    w_state_d    = StStop;
                    w_stop_idx_d = '0;
                end
            end
            StStop: begin
                if (w_tick) begin
                    if (r_stop_idx == STOP_LAST) begin
                        w_state_d = StIdle;
                    end else begin
                        w_stop_idx_d = r_stop_idx + 2'd1;
                    end
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    // Output values for the next cycle, derived from the next state.
    always_comb begin
        case (w_state_d)
            StStart:  w_tx_out_d = 1'b0;
            StData:   w_tx_out_d = w_shift_d[0];
            StParity: w_tx_out_d = w_par_bit_d;
            default:  w_tx_out_d = 1'b1;
        endcase
        w_busy_d    = (w_state_d != StIdle);
        w_ready_d   = (w_state_d == StIdle);
        w_done_d    = (r_state == StStop) && (w_state_d == StIdle);
        w_div_err_d = i_div_ld && (r_state != StIdle);
    end

    assign o_tx_out   = r_tx_out;
    assign o_tx_busy  = r_busy;
    assign o_tx_done  = r_done;
    assign o_tx_ready = r_ready;
    assign o_div_err  = r_div_err;

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Bench for uart_tx_sequencer: directed frame table, back-to-back, rejected
// divisor load, mid-frame reset, then randomised frames against a line model.
module tb_uart_tx_sequencer;

    localparam int unsigned STOP_BITS = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] div_val;
    logic        div_ld;
    logic        div_err;
    logic        par_en;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        tx_out;
    logic        tx_busy;
    logic        tx_done;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    uart_tx_sequencer dut (
        .i_clk_in   (clk),
        .i_tx_rst   (rst),
        .i_div_val  (div_val),
        .i_div_ld   (div_ld),
        .o_div_err  (div_err),
        .i_par_en   (par_en),
        .i_tx_data  (tx_data),
        .i_tx_valid (tx_valid),
        .o_tx_ready (tx_ready),
        .o_tx_out   (tx_out),
        .o_tx_busy  (tx_busy),
        .o_tx_done  (tx_done)
    );

    typedef struct {
        logic [7:0]  data;
        logic        par;
        logic [15:0] div_val;
        int          period;
        int          n_bits;
        logic [11:0] bits;   // bit i = i-th bit on the line
    } vec_t;

    // {out, busy, done, ready, err}
    function automatic logic [4:0] obs();
        return {tx_out, tx_busy, tx_done, tx_ready, div_err};
    endfunction

    task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got {out,busy,done,ready,err}=%b, want %b at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Line model: start, LSB-first data, optional even parity, stop bits.
    function automatic void model(input logic [7:0] d, input logic p,
                                  output logic [11:0] bits, output int n);
        bits = '0;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[1+i] = d[i];
        n = 9;
        if (p) begin
            bits[n] = ^d;
            n++;
        end
        for (int s = 0; s < STOP_BITS; s++) begin
            bits[n] = 1'b1;
            n++;
        end
    endfunction

    // Leaves the bench one cycle after the handshake edge (first start-bit cycle).
    task automatic send(input logic [7:0] d, input logic p, input logic [15:0] dv,
                        input bit hold, input bit same);
        div_ld  = 1'b1;
        div_val = dv;
        if (same) begin
            tx_valid = 1'b1;
            tx_data  = d;
            par_en   = p;
        end else begin
            step();
            div_ld   = 1'b0;
            tx_valid = 1'b1;
            tx_data  = d;
            par_en   = p;
        end
        step();
        div_ld = 1'b0;
        if (!hold) begin
            tx_valid = 1'b0;
            tx_data  = 8'($urandom);
            par_en   = 1'($urandom);
        end
    endtask

    // Checks every cycle of the frame, then the done cycle. Optional rejected
    // divisor load at cycle ld_at, optional reset at cycle rst_at (aborts).
    task automatic check_frame(input logic [11:0] bits, input int n, input int p,
                               input int ld_at, input int rst_at);
        for (int k = 0; k < n * p; k++) begin
            check($sformatf("frame bit %0d cycle %0d", k / p, k), obs(),
                  {bits[k / p], 1'b1, 1'b0, 1'b0, (ld_at >= 0) && (k == ld_at + 1)});
            if (k == rst_at) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
                check("reset abort", obs(), 5'b10010);
                return;
            end
            div_ld  = (k == ld_at);
            div_val = 16'd8;
            step();
        end
        div_ld = 1'b0;
        check("frame done", obs(), 5'b10110);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t        tbl[6];
        logic [11:0] b;
        int          n;
        logic [7:0]  d;
        logic        p;
        logic [15:0] dv;

        tbl[0] = '{8'hA5, 1'b0, 16'd4, 4, 10, 12'b0011_0100_1010};
        tbl[1] = '{8'h07, 1'b1, 16'd4, 4, 11, 12'b0110_0000_1110};
        tbl[2] = '{8'h00, 1'b1, 16'd1, 2, 11, 12'b0100_0000_0000};
        tbl[3] = '{8'hFF, 1'b0, 16'd0, 2, 10, 12'b0011_1111_1110};
        tbl[4] = '{8'hF0, 1'b0, 16'd3, 3, 10, 12'b0011_1110_0000};
        tbl[5] = '{8'h5A, 1'b1, 16'd5, 5, 11, 12'b0100_1011_0100};

        rst = 1'b1; div_ld = 1'b0; div_val = '0; par_en = 1'b0;
        tx_data = '0; tx_valid = 1'b0;
        step();
        step();
        rst = 1'b0;

        // Idle after reset.
        for (int i = 0; i < 100; i++) check("idle after reset", obs(), 5'b10010);
        step();

        // Directed frames.
        for (int i = 0; i < 6; i++) begin
            send(tbl[i].data, tbl[i].par, tbl[i].div_val, 1'b0, 1'b0);
            check_frame(tbl[i].bits, tbl[i].n_bits, tbl[i].period, -1, -1);
        end

        // Back-to-back with valid held: 0x55 then 0xAA, one idle-high cycle between.
        send(8'h55, 1'b0, 16'd4, 1'b1, 1'b0);
        tx_data = 8'hAA;
        par_en  = 1'b0;
        check_frame(12'b0010_1010_1010, 10, 4, -1, -1);
        step();
        tx_valid = 1'b0;
        check_frame(12'b0011_0101_0100, 10, 4, -1, -1);

        // Rejected divisor load mid-frame: error pulse, bit period unchanged.
        send(8'hA5, 1'b0, 16'd4, 1'b0, 1'b0);
        check_frame(12'b0011_0100_1010, 10, 4, 9, -1);

        // Reset in data bit 3, then a clean frame.
        model(8'h3C, 1'b0, b, n);
        send(8'h3C, 1'b0, 16'd4, 1'b0, 1'b0);
        check_frame(b, n, 4, -1, 17);
        model(8'hC3, 1'b1, b, n);
        send(8'hC3, 1'b1, 16'd4, 1'b0, 1'b0);
        check_frame(b, n, 4, -1, -1);

        // Randomised frames, sometimes loading the divisor in the handshake cycle.
        for (int i = 0; i < 24; i++) begin
            int gap;
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                step();
                check("idle gap", obs(), 5'b10010);
            end
            d  = 8'($urandom);
            p  = 1'($urandom);
            dv = 16'($urandom_range(0, 6));
            model(d, p, b, n);
            send(d, p, dv, 1'b0, 1'($urandom));
            check_frame(b, n, (dv < 16'd2) ? 2 : int'(dv), -1, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
